// File: rtl/axi_arb_pkg.sv
// Shared types, default parameters and the round-robin pick helper for the
// AXI slave-port arbiter.
package axi_arb_pkg;

   typedef enum logic {IDLE, GRANT} arb_state_t;

   localparam int unsigned DEF_NUM_MASTERS = 3;
   localparam int unsigned DEF_TIMEOUT     = 256;
   localparam int unsigned MAX_MASTERS     = 8;
   localparam int unsigned IDX_W           = 3;

   typedef struct packed {
      logic             found;
      logic [IDX_W-1:0] idx;
   } rr_pick_t;

   // First requester scanning cyclically from last+1 over the n active masters.
   function automatic rr_pick_t rr_pick(input logic [MAX_MASTERS-1:0] req,
                                        input logic [IDX_W-1:0]       last,
                                        input int unsigned            n);
      rr_pick_t    res;
      logic [31:0] c;
      res = '0;
      for (int unsigned k = 1; k <= MAX_MASTERS; k++) begin
         if (k <= n) begin
            c = (32'(last) + k) % n;
            if (!res.found && req[c[IDX_W-1:0]]) begin
               res.found = 1'b1;
               res.idx   = c[IDX_W-1:0];
            end
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/axi_arb_channel.sv
// One arbitrated channel: IDLE/GRANT FSM, round-robin pointer and grant
// watchdog. The grant is held until done_i or the watchdog expires.
module axi_arb_channel
   import axi_arb_pkg::*;
#(
   parameter int unsigned NUM_MASTERS = DEF_NUM_MASTERS,
   parameter int unsigned TIMEOUT     = DEF_TIMEOUT,
   parameter int unsigned SEL_W       = $clog2(NUM_MASTERS)
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic [NUM_MASTERS-1:0] req_i,
   input  logic                   done_i,
   output logic [NUM_MASTERS-1:0] gnt_o,
   output logic [SEL_W-1:0]       sel_o,
   output logic                   busy_o,
   output logic                   to_o
);

   localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
   localparam logic [SEL_W-1:0] LAST_RST = SEL_W'(NUM_MASTERS - 1);

   arb_state_t             state_q, state_d;
   logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
   logic [SEL_W-1:0]       sel_q, sel_d;
   logic [SEL_W-1:0]       last_q, last_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   busy_q, busy_d;
   logic                   to_q, to_d;
   rr_pick_t               pick;
   logic                   expire;

   always_comb begin
      pick   = rr_pick(MAX_MASTERS'(req_i), IDX_W'(last_q), NUM_MASTERS);
      // Completion takes priority over the watchdog in the same cycle.
      expire = (TIMEOUT != 0) && !done_i && (cnt_q == CNT_LAST);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         sel_q   <= '0;
         last_q  <= LAST_RST;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         to_q    <= to_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (pick.found) state_d = GRANT;
         GRANT:   if (done_i || expire) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      gnt_d  = gnt_q;
      sel_d  = sel_q;
      last_d = last_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      to_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (pick.found) begin
               gnt_d  = NUM_MASTERS'(1) << pick.idx;
               sel_d  = SEL_W'(pick.idx);
               busy_d = 1'b1;
            end else begin
               gnt_d  = '0;
               sel_d  = '0;
               busy_d = 1'b0;
            end
         end
         GRANT: begin
            if (done_i || expire) begin
               gnt_d  = '0;
               sel_d  = '0;
               busy_d = 1'b0;
               last_d = sel_q;
               cnt_d  = '0;
               to_d   = expire;
            end else if (TIMEOUT != 0) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            gnt_d  = '0;
            sel_d  = '0;
            busy_d = 1'b0;
         end
      endcase
   end

   assign gnt_o  = gnt_q;
   assign sel_o  = sel_q;
   assign busy_o = busy_q;
   assign to_o   = to_q;

endmodule

// File: rtl/axi_rr_arbiter.sv
// Round-robin arbiter for the shared simplified-AXI slave port; write and read
// channels are arbitrated independently by two channel instances.
module axi_rr_arbiter
   import axi_arb_pkg::*;
#(
   parameter int unsigned NUM_MASTERS = DEF_NUM_MASTERS,
   parameter int unsigned TIMEOUT     = DEF_TIMEOUT,
   parameter int unsigned SEL_W       = $clog2(NUM_MASTERS)
) (
   input  logic                   aclk,
   input  logic                   rst_n,
   input  logic [NUM_MASTERS-1:0] req_w,
   input  logic [NUM_MASTERS-1:0] req_r,
   input  logic                   BVALID,
   input  logic                   BREADY,
   input  logic                   RVALID,
   input  logic                   RREADY,
   input  logic                   RLAST,
   output logic [NUM_MASTERS-1:0] gnt_w,
   output logic [NUM_MASTERS-1:0] gnt_r,
   output logic [SEL_W-1:0]       sel_w,
   output logic [SEL_W-1:0]       sel_r,
   output logic                   busy_w,
   output logic                   busy_r,
   output logic                   to_w,
   output logic                   to_r
);

   logic done_w;
   logic done_r;

   // Reads complete only on the final beat of the burst.
   assign done_w = BVALID & BREADY;
   assign done_r = RVALID & RREADY & RLAST;

   axi_arb_channel #(
      .NUM_MASTERS (NUM_MASTERS),
      .TIMEOUT     (TIMEOUT),
      .SEL_W       (SEL_W)
   ) u_chan_w (
      .clk_i  (aclk),
      .rst_ni (rst_n),
      .req_i  (req_w),
      .done_i (done_w),
      .gnt_o  (gnt_w),
      .sel_o  (sel_w),
      .busy_o (busy_w),
      .to_o   (to_w)
   );

   axi_arb_channel #(
      .NUM_MASTERS (NUM_MASTERS),
      .TIMEOUT     (TIMEOUT),
      .SEL_W       (SEL_W)
   ) u_chan_r (
      .clk_i  (aclk),
      .rst_ni (rst_n),
      .req_i  (req_r),
      .done_i (done_r),
      .gnt_o  (gnt_r),
      .sel_o  (sel_r),
      .busy_o (busy_r),
      .to_o   (to_r)
   );

endmodule

// File: tb/tb_axi_rr_arbiter.sv
// Directed bench for axi_rr_arbiter: 3 masters, watchdog of 8 cycles.
module tb_axi_rr_arbiter;

   localparam int unsigned NM    = 3;
   localparam int unsigned TO    = 8;
   localparam int unsigned SEL_W = 2;

   logic          aclk;
   logic          rst_n;
   logic [NM-1:0] req_w, req_r;
   logic          BVALID, BREADY, RVALID, RREADY, RLAST;
   logic [NM-1:0] gnt_w, gnt_r;
   logic [SEL_W-1:0] sel_w, sel_r;
   logic          busy_w, busy_r, to_w, to_r;

   int n_checks = 0;
   int n_errors = 0;

   axi_rr_arbiter #(
      .NUM_MASTERS (NM),
      .TIMEOUT     (TO),
      .SEL_W       (SEL_W)
   ) dut (
      .aclk   (aclk),
      .rst_n  (rst_n),
      .req_w  (req_w),
      .req_r  (req_r),
      .BVALID (BVALID),
      .BREADY (BREADY),
      .RVALID (RVALID),
      .RREADY (RREADY),
      .RLAST  (RLAST),
      .gnt_w  (gnt_w),
      .gnt_r  (gnt_r),
      .sel_w  (sel_w),
      .sel_r  (sel_r),
      .busy_w (busy_w),
      .busy_r (busy_r),
      .to_w   (to_w),
      .to_r   (to_r)
   );

   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Inputs are driven and outputs sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic b_pulse();
      BVALID = 1'b1;
      BREADY = 1'b1;
      tick();
      BVALID = 1'b0;
      BREADY = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      logic [NM-1:0] exp_g [4];
      logic [1:0]    exp_s [4];
      exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100; exp_g[3] = 3'b001;
      exp_s[0] = 2'd0;   exp_s[1] = 2'd1;   exp_s[2] = 2'd2;   exp_s[3] = 2'd0;

      rst_n = 1'b1;
      req_w = '0; req_r = '0;
      BVALID = 1'b0; BREADY = 1'b0; RVALID = 1'b0; RREADY = 1'b0; RLAST = 1'b0;
      #1 rst_n = 1'b0;
      tick();
      check("rst_gnt_w", 32'(gnt_w), 0);
      check("rst_gnt_r", 32'(gnt_r), 0);
      check("rst_sel_w", 32'(sel_w), 0);
      check("rst_busy_w", 32'(busy_w), 0);
      check("rst_to_w", 32'(to_w), 0);
      #2 rst_n = 1'b1;

      // 1: all write requesters, rotating grants with one idle cycle between.
      req_w = 3'b111;
      tick();
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t1_gnt%0d", i), 32'(gnt_w), 32'(exp_g[i]));
         check($sformatf("t1_sel%0d", i), 32'(sel_w), 32'(exp_s[i]));
         check($sformatf("t1_busy%0d", i), 32'(busy_w), 1);
         tick();
         tick();
         check($sformatf("t1_hold%0d", i), 32'(gnt_w), 32'(exp_g[i]));
         b_pulse();
         if (i == 3) req_w = '0;
         check($sformatf("t1_idle%0d", i), 32'(gnt_w), 0);
         check($sformatf("t1_idle_busy%0d", i), 32'(busy_w), 0);
         if (i < 3) tick();
      end
      tick();
      check("t1_no_req", 32'(gnt_w), 0);

      // 2: M1 read burst of 4 beats, only the last releases.
      req_r = 3'b010;
      tick();
      check("t2_gnt", 32'(gnt_r), 32'(3'b010));
      check("t2_sel", 32'(sel_r), 1);
      req_r = '0;
      RVALID = 1'b1; RREADY = 1'b1;
      for (int b = 1; b <= 3; b++) begin
         tick();
         check($sformatf("t2_beat%0d", b), 32'(gnt_r), 32'(3'b010));
         check($sformatf("t2_busy%0d", b), 32'(busy_r), 1);
      end
      RLAST = 1'b1;
      tick();
      RVALID = 1'b0; RREADY = 1'b0; RLAST = 1'b0;
      check("t2_rel", 32'(gnt_r), 0);
      check("t2_rel_busy", 32'(busy_r), 0);
      check("t2_gnt_w", 32'(gnt_w), 0);

      // 3: M2 write grant abandoned, watchdog releases after 8 cycles.
      req_w = 3'b100;
      tick();
      check("t3_gnt", 32'(gnt_w), 32'(3'b100));
      req_w = '0;
      for (int c = 1; c <= 7; c++) begin
         tick();
         check($sformatf("t3_hold%0d", c), 32'(gnt_w), 32'(3'b100));
         check($sformatf("t3_to%0d", c), 32'(to_w), 0);
      end
      tick();
      check("t3_rel", 32'(gnt_w), 0);
      check("t3_to_pulse", 32'(to_w), 1);
      req_w = 3'b011;
      tick();
      check("t3_to_clr", 32'(to_w), 0);
      check("t3_next", 32'(gnt_w), 32'(3'b001));

      // 4: completion in the last watchdog cycle wins over the timeout.
      req_w = '0;
      for (int c = 1; c <= 7; c++) tick();
      check("t4_hold", 32'(gnt_w), 32'(3'b001));
      b_pulse();
      check("t4_rel", 32'(gnt_w), 0);
      check("t4_to", 32'(to_w), 0);
      tick();
      check("t4_to_after", 32'(to_w), 0);

      // 5: both channels grant M0 together; write completion leaves read alone.
      req_w = 3'b001;
      req_r = 3'b001;
      tick();
      check("t5_gnt_w", 32'(gnt_w), 32'(3'b001));
      check("t5_gnt_r", 32'(gnt_r), 32'(3'b001));
      req_w = '0;
      req_r = '0;
      b_pulse();
      check("t5_w_rel", 32'(gnt_w), 0);
      check("t5_r_held", 32'(gnt_r), 32'(3'b001));
      RVALID = 1'b1; RREADY = 1'b1; RLAST = 1'b1;
      tick();
      RVALID = 1'b0; RREADY = 1'b0; RLAST = 1'b0;
      check("t5_r_rel", 32'(gnt_r), 0);

      // 6: serve M1 (pointer 1), grant M2, then async reset mid-grant.
      req_w = 3'b010;
      tick();
      check("t6_m1", 32'(gnt_w), 32'(3'b010));
      req_w = '0;
      b_pulse();
      tick();
      req_w = 3'b100;
      tick();
      check("t6_m2", 32'(gnt_w), 32'(3'b100));
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_gnt", 32'(gnt_w), 0);
      check("t6_rst_busy", 32'(busy_w), 0);
      check("t6_rst_sel", 32'(sel_w), 0);
      req_w = 3'b110;
      tick();
      #2 rst_n = 1'b1;
      tick();
      check("t6_after_gnt", 32'(gnt_w), 32'(3'b010));
      check("t6_after_sel", 32'(sel_w), 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
